// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : timer_pkg
// Summary  : Shared definitions for the timer_dev countdown timer: register
//            offsets, FSM state encoding, MODE values, CTRL bit positions and
//            a byte-lane merge helper for bus writes.
// Revision : 1.0 - initial release
// ============================================================================
package timer_pkg;

  // Register offsets as decoded from addr[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_PSC    = 2'd3;

  // Countdown FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CNT  = 2'd1,
    INT  = 2'd2
  } state_t;

  // CTRL.MODE values; 2'b10 and 2'b11 fall back to one-shot behaviour
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // CTRL field positions
  localparam int CTRL_W        = 4;
  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;

  // Replace the byte lanes of old_val selected by be with those of new_val
  function automatic logic [31:0] byte_merge(
    input logic [31:0] old_val,
    input logic [31:0] new_val,
    input logic [3:0]  be
  );
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : timer_prescaler
// Summary  : Divides the countdown rate of timer_dev. tick is asserted on the
//            cycle where the internal prescale counter has reached PSC; the
//            counter then restarts from zero. PSC=0 ticks on every running
//            cycle.
// Build    : only present when TIMER_PRESCALE_EN is defined, since it is the
//            only consumer of this block.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef TIMER_PRESCALE_EN
module timer_prescaler (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] psc,
  output logic        tick
);

  logic [15:0] pcnt;

  // >= rather than == so that lowering PSC below the current count cannot
  // make the counter run the long way round through 16-bit wrap.
  assign tick = run && (pcnt >= psc);

  // Prescale counter: held at zero whenever the timer is not actively
  // counting, which covers both a fresh load (IDLE/INT -> CNT) and a pause.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
    end else if (!run || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 16'd1;
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/timer_dev.sv
`default_nettype none
// ============================================================================
// Module   : timer_dev
// Summary  : Memory-mapped 32-bit countdown timer with one-shot and
//            auto-reload modes and a registered interrupt request.
//            Register map (addr[3:2]): 0 CTRL, 1 PRESET, 2 COUNT (RO),
//            3 PSC (prescale builds only, reads 0 otherwise).
// Build    : define TIMER_PRESCALE_EN to add the PSC register and the
//            timer_prescaler rate divider.
// Revision : 1.0 - initial release
// ============================================================================
module timer_dev
  import timer_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [1:0]        reg_sel;
  logic              wr_ctrl;
  logic              wr_preset;
  logic [CTRL_W-1:0] ctrl;
  logic [CTRL_W-1:0] ctrl_nxt;
  logic [31:0]       preset;
  logic [31:0]       preset_nxt;
  logic [31:0]       count;
  logic [31:0]       count_nxt;
  state_t            state;
  state_t            state_nxt;
  logic              int_flag;
  logic              int_flag_nxt;
  logic              irq_nxt;
  logic [1:0]        mode;
  logic              run;
  logic              tick;
  logic              unused_addr;

  // Only the word offset is decoded; upper and byte-offset bits are don't-care
  assign reg_sel     = addr[3:2];
  assign unused_addr = ^{addr[31:4], addr[1:0]};

  // CTRL only lives in byte lane 0, so a write without byteen[0] is a no-op
  assign wr_ctrl   = we && (reg_sel == REG_CTRL) && byteen[0];
  assign wr_preset = we && (reg_sel == REG_PRESET);

  assign mode = ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB];
  assign run  = (state == CNT) && ctrl[CTRL_EN];

`ifdef TIMER_PRESCALE_EN
  logic [15:0] psc;
  logic [15:0] psc_nxt;
  logic        wr_psc;

  assign wr_psc = we && (reg_sel == REG_PSC);

  // PSC next value: per-byte writes on the low two lanes
  always_comb begin
    psc_nxt = psc;
    if (wr_psc) begin
      if (byteen[0]) psc_nxt[7:0]  = wdata[7:0];
      if (byteen[1]) psc_nxt[15:8] = wdata[15:8];
    end
  end

  // PSC register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      psc <= '0;
    end else begin
      psc <= psc_nxt;
    end
  end

  timer_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .psc   (psc),
    .tick  (tick)
  );
`else
  // Without a prescaler every enabled CNT cycle is a decrement cycle
  assign tick = 1'b1;
`endif

  // Next-state and datapath: FSM update first, then bus writes override it
  always_comb begin
    state_nxt    = state;
    ctrl_nxt     = ctrl;
    preset_nxt   = preset;
    count_nxt    = count;
    int_flag_nxt = int_flag;

    case (state)
      IDLE: begin
        if (ctrl[CTRL_EN]) begin
          count_nxt = preset;
          state_nxt = CNT;
        end
      end
      CNT: begin
        // EN low pauses here: COUNT and state simply hold
        if (run && tick) begin
          // <= 1 rather than == 1 so a PRESET of 0 expires like 1 and the
          // count can never wrap below zero
          if (count <= 32'd1) begin
            count_nxt    = '0;
            state_nxt    = INT;
            int_flag_nxt = 1'b1;
          end else begin
            count_nxt = count - 32'd1;
          end
        end
      end
      INT: begin
        if (mode == MODE_RELOAD) begin
          count_nxt    = preset;
          state_nxt    = CNT;
          int_flag_nxt = 1'b0;
        end else begin
          // MODE_ONESHOT and the two reserved encodings: stop and keep the flag
          ctrl_nxt[CTRL_EN] = 1'b0;
          state_nxt         = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Bus writes take priority over FSM side effects in the same cycle
    if (wr_ctrl) begin
      ctrl_nxt     = wdata[CTRL_W-1:0];
      int_flag_nxt = 1'b0;
    end
    if (wr_preset) begin
      preset_nxt   = byte_merge(preset, wdata, byteen);
      int_flag_nxt = 1'b0;
    end

    // irq is registered from the post-update values so it rises on the same
    // edge that enters INT and falls on the edge of a clearing write
    irq_nxt = ctrl_nxt[CTRL_IM] & int_flag_nxt;
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Control/data registers and the interrupt request flop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl     <= '0;
      preset   <= PRESET_RST;
      count    <= '0;
      int_flag <= 1'b0;
      irq      <= 1'b0;
    end else begin
      ctrl     <= ctrl_nxt;
      preset   <= preset_nxt;
      count    <= count_nxt;
      int_flag <= int_flag_nxt;
      irq      <= irq_nxt;
    end
  end

  // Combinational read mux
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, ctrl};
      REG_PRESET: rdata = preset;
      REG_COUNT:  rdata = count;
`ifdef TIMER_PRESCALE_EN
      REG_PSC:    rdata = {16'd0, psc};
`endif
      default:    rdata = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_timer_dev.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_dev
// Summary  : Directed bench for timer_dev. The driver issues one bus cycle
//            per clock and, for read probes, queues the expected CTRL/PRESET/
//            COUNT read value and irq level; a monitor pops and compares on
//            the falling edge whenever a probe is presented.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_dev;

  localparam logic [31:0] A_CTRL   = 32'h0000_7f00;
  localparam logic [31:0] A_PRESET = 32'h0000_7f04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7f08;
  localparam logic [31:0] A_OFF3   = 32'h0000_7f0c;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic [31:0] addr   = A_CTRL;
  logic        we     = 1'b0;
  logic [3:0]  byteen = 4'h0;
  logic [31:0] wdata  = 32'h0;
  logic [31:0] rdata;
  logic        irq;

  logic probe = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t sb[$];

  timer_dev #(.PRESET_RST(32'h0)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  // Monitor: compare the presented read value and irq against the queue head
  always @(negedge clk) begin
    if (probe) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: rdata=0x%08h irq=%0b, no expected entry", rdata, irq);
      end else begin
        e = sb.pop_front();
        if (rdata !== e.data || irq !== e.irq) begin
          errors++;
          $display("FAIL %s: rdata=0x%08h irq=%0b, expected rdata=0x%08h irq=%0b",
                   e.name, rdata, irq, e.data, e.irq);
        end
      end
    end
  end

  // One bus cycle, driven just after the rising edge
  task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic p);
    @(posedge clk);
    #1;
    we     = w;
    addr   = a;
    wdata  = d;
    byteen = be;
    probe  = p;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    cyc(1'b1, a, d, be, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, A_CTRL, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] d, input logic i);
    exp_t e;
    cyc(1'b0, a, 32'h0, 4'h0, 1'b1);
    e.name = n;
    e.data = d;
    e.irq  = i;
    sb.push_back(e);
  endtask

  // Assert reset between edges and probe before the next edge arrives
  task automatic rst_chk(input string n, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    @(posedge clk);
    #1;
    reset = 1'b0;
    we    = 1'b0;
    addr  = a;
    probe = 1'b1;
    e.name = n;
    e.data = d;
    e.irq  = 1'b0;
    sb.push_back(e);
  endtask

  task automatic rst_release();
    @(posedge clk);
    #1;
    reset = 1'b1;
    probe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    rst_release();

    // Reset values
    chk("rst_ctrl",   A_CTRL,   32'h0, 1'b0);
    chk("rst_preset", A_PRESET, 32'h0, 1'b0);
    chk("rst_count",  A_COUNT,  32'h0, 1'b0);
    chk("rst_off3",   A_OFF3,   32'h0, 1'b0);

    // One-shot, PRESET=3: COUNT 3,2,1,0 after E0+1..E0+4, irq held
    wr(A_PRESET, 32'd3, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    chk("os_k0_count", A_COUNT, 32'd0, 1'b0);
    chk("os_k1_count", A_COUNT, 32'd3, 1'b0);
    chk("os_k2_count", A_COUNT, 32'd2, 1'b0);
    chk("os_k3_count", A_COUNT, 32'd1, 1'b0);
    chk("os_k4_count", A_COUNT, 32'd0, 1'b1);
    chk("os_k5_ctrl",  A_CTRL,  32'h8, 1'b1);
    chk("os_k6_hold",  A_COUNT, 32'd0, 1'b1);
    wr(A_CTRL, 32'h0, 4'hF);
    chk("os_irq_clr",  A_CTRL,  32'h0, 1'b0);

    // Collision: CTRL write in the INT cycle keeps EN and restarts the count
    wr(A_PRESET, 32'd2, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    chk("col_k0_count", A_COUNT, 32'd0, 1'b0);
    chk("col_k1_count", A_COUNT, 32'd2, 1'b0);
    chk("col_k2_count", A_COUNT, 32'd1, 1'b0);
    wr(A_CTRL, 32'h9, 4'hF);
    chk("col_k4_ctrl",  A_CTRL,  32'h9, 1'b0);
    chk("col_k5_reload", A_COUNT, 32'd2, 1'b0);
    chk("col_k6_count", A_COUNT, 32'd1, 1'b0);
    chk("col_k7_int",   A_COUNT, 32'd0, 1'b1);
    chk("col_k8_ctrl",  A_CTRL,  32'h8, 1'b1);
    wr(A_CTRL, 32'h0, 4'hF);

    // PRESET=0 behaves like 1: INT after E0+2, no wrap below zero
    wr(A_PRESET, 32'd0, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    chk("p0_k0_count", A_COUNT, 32'd0, 1'b0);
    chk("p0_k1_count", A_COUNT, 32'd0, 1'b0);
    chk("p0_k2_int",   A_COUNT, 32'd0, 1'b1);
    chk("p0_k3_ctrl",  A_CTRL,  32'h8, 1'b1);

    // Asynchronous reset with irq high: irq and CTRL drop before any edge
    rst_chk("arst_ctrl_irq", A_CTRL, 32'h0);
    rst_release();
    chk("arst_after", A_CTRL, 32'h0, 1'b0);

    // Auto-reload, PRESET=2: 3-cycle period, 1-cycle irq pulse, 10 periods
    wr(A_PRESET, 32'd2, 4'hF);
    wr(A_CTRL, 32'hB, 4'hF);
    chk("ar_k0_count", A_COUNT, 32'd0, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      logic [31:0] ev;
      ev = (k % 3 == 1) ? 32'd2 : ((k % 3 == 2) ? 32'd1 : 32'd0);
      chk($sformatf("ar_k%0d_count", k), A_COUNT, ev, (k % 3 == 0));
    end
    // Switch to one-shot without IM so it runs out and parks in IDLE
    wr(A_CTRL, 32'h1, 4'hF);
    idle(3);
    chk("ar_stop_ctrl",  A_CTRL,  32'h0, 1'b0);
    chk("ar_stop_im",    A_COUNT, 32'd0, 1'b0);

    // Pause at COUNT=6 for 4 cycles, PRESET rewritten while paused
    wr(A_PRESET, 32'd10, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    chk("pz_k0_count", A_COUNT, 32'd0,  1'b0);
    chk("pz_k1_count", A_COUNT, 32'd10, 1'b0);
    chk("pz_k2_count", A_COUNT, 32'd9,  1'b0);
    chk("pz_k3_count", A_COUNT, 32'd8,  1'b0);
    wr(A_CTRL, 32'h8, 4'hF);
    chk("pz_k5_hold",  A_COUNT, 32'd6,  1'b0);
    wr(A_PRESET, 32'd3, 4'hF);
    chk("pz_k7_hold",  A_COUNT, 32'd6,  1'b0);
    chk("pz_k8_hold",  A_COUNT, 32'd6,  1'b0);
    wr(A_CTRL, 32'h9, 4'hF);
    chk("pz_k10_count", A_COUNT, 32'd6, 1'b0);
    chk("pz_k11_count", A_COUNT, 32'd5, 1'b0);
    chk("pz_k12_count", A_COUNT, 32'd4, 1'b0);
    chk("pz_k13_count", A_COUNT, 32'd3, 1'b0);
    chk("pz_k14_count", A_COUNT, 32'd2, 1'b0);
    chk("pz_k15_count", A_COUNT, 32'd1, 1'b0);
    chk("pz_k16_int",   A_COUNT, 32'd0, 1'b1);
    chk("pz_k17_ctrl",  A_CTRL,  32'h8, 1'b1);
    wr(A_CTRL, 32'h0, 4'hF);
    chk("pz_preset",    A_PRESET, 32'd3, 1'b0);

    // Reset asserted mid-count with COUNT=5
    wr(A_PRESET, 32'd8, 4'hF);
    wr(A_CTRL, 32'h1, 4'hF);
    chk("mr_k0_count", A_COUNT, 32'd0, 1'b0);
    chk("mr_k1_count", A_COUNT, 32'd8, 1'b0);
    chk("mr_k2_count", A_COUNT, 32'd7, 1'b0);
    chk("mr_k3_count", A_COUNT, 32'd6, 1'b0);
    rst_chk("mr_async_count", A_COUNT, 32'd0);
    rst_release();
    chk("mr_ctrl_alias", 32'h0000_7f13, 32'h0, 1'b0);

    // Byte-lane writes, read-only COUNT, offset 3, CTRL upper bits
    wr(A_PRESET, 32'h0, 4'hF);
    wr(A_PRESET, 32'hAABB_CCDD, 4'b0101);
    chk("bw_preset", A_PRESET, 32'h00BB_00DD, 1'b0);
    wr(A_COUNT, 32'h1234_5678, 4'hF);
    chk("bw_count_ro", A_COUNT, 32'h0, 1'b0);
    wr(A_OFF3, 32'h0000_1234, 4'hF);
`ifdef TIMER_PRESCALE_EN
    chk("bw_off3", A_OFF3, 32'h0000_1234, 1'b0);
`else
    chk("bw_off3", A_OFF3, 32'h0, 1'b0);
`endif
    wr(A_CTRL, 32'hFFFF_FFFF, 4'b1110);
    chk("bw_ctrl_lane0", A_CTRL, 32'h0, 1'b0);
    wr(A_CTRL, 32'hFFFF_FFFF, 4'hF);
    chk("bw_ctrl_mask", 32'h0000_7f10, 32'hF, 1'b0);

    // Let the last probe be sampled, then confirm nothing is left queued
    cyc(1'b0, A_CTRL, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped countdown timer on the CPU's external bridge, at base 0x7f00 (second instance at 0x7f10).
- Sits directly upstream of the CPU's `interrupt` input: its `irq` drives one hardware-interrupt line into CP0.
- Programmed by sw/lw through the bridge. Provides the one-shot and periodic interrupts used by the exception-handler tests.

Parameters:
- PRESET_RST, 32'h0, reset value of PRESET.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset; reset=0 clears all state immediately.
- addr  in  32  byte address from bridge; only addr[3:2] decoded, addr[1:0] ignored.
- we  in  1  write strobe, valid for one cycle.
- byteen  in  4  per-byte write enables, qualified by we.
- wdata  in  32  write data.
- rdata  out  32  combinational read data for addr[3:2].
- irq  out  1  registered interrupt request to CPU.

Behaviour:
- Register map (addr[3:2]):
  - 0 = CTRL: [0] EN, [2:1] MODE, [3] IM. Bits [31:4] read 0 and writes to them are ignored. Only byteen[0] is honoured.
  - 1 = PRESET: full 32 bits, per-byte writes.
  - 2 = COUNT: read-only; writes are ignored.
  - 3 reads 0 (see optional feature).
- MODE values: 00 = one-shot; 01 = auto-reload; 10 and 11 behave as 00.
- Reset: CTRL=0, PRESET=PRESET_RST, COUNT=0, state=IDLE, int_flag=0, irq=0.
- States: IDLE, CNT, INT.
  - IDLE: if EN, then COUNT<=PRESET and go to CNT. Otherwise hold.
  - CNT, EN=1: if COUNT<=1, then COUNT<=0 and go to INT. Otherwise COUNT<=COUNT-1.
  - CNT, EN=0: pause. COUNT holds and state stays CNT. Counting resumes when EN returns to 1.
  - INT, MODE=00: CTRL.EN<=0 and go to IDLE. int_flag<=1 and stays set.
  - INT, MODE=01: COUNT<=PRESET and go to CNT. int_flag is high for exactly this one cycle.
- irq = registered (IM & int_flag).
- int_flag clears on any CTRL or PRESET write.
- Latency: CTRL write with EN=1 captured at edge E0 and PRESET=N≥1:
  - COUNT=N after E0+1.
  - COUNT=0, state INT and irq=1 after E0+N+1.
- Auto-reload period: N+1 cycles between irq pulses.
- PRESET=0: behaves like N=1, so INT is reached after E0+2.
- Simultaneous write and FSM update of the same register: the bus write wins. A CTRL write in the INT cycle overrides the EN auto-clear.
- PRESET write during CNT: the running count is unaffected; the new value is used at the next load.
- Wrap-around: the decrement never goes below 0; no 32-bit wrap.
- Reset asserted mid-count: everything returns to reset values asynchronously. irq drops without waiting for a clock edge.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - addr[3:2]=3 is PSC, a 16-bit read/write register in bits [15:0]; reset value 0.
  - In CNT, COUNT decrements only when an internal prescale counter reaches PSC. The prescale counter then restarts at 0.
  - The prescale counter clears on load and on pause.
  - PSC=0 gives identical timing to the undefined build.
- Undefined: offset 3 reads 0 and writes are ignored; decrement on every enabled cycle.

Decomposition:
- Package timer_pkg holds:
  - register offsets REG_CTRL/REG_PRESET/REG_COUNT/REG_PSC;
  - state encoding IDLE/CNT/INT;
  - MODE_ONESHOT/MODE_RELOAD;
  - CTRL bit indices.
- One natural sub-module: timer_prescaler. Instantiated only under TIMER_PRESCALE_EN; outputs a tick enable.

Test Plan:
- Reset check: assert reset=0 mid-count with COUNT=5 → COUNT=0, irq=0, rdata(CTRL)=0 immediately, before any clock edge.
- One-shot: PRESET=3, then CTRL=0x9 (EN, mode 0, IM) at E0 → COUNT reads 3,2,1,0 after E0+1..E0+4; irq=1 from E0+4 and held; EN=0 afterwards; write CTRL=0 → irq=0 next cycle.
- Auto-reload: PRESET=2, CTRL=0xB → irq pulses one cycle wide every 3 cycles; over 10 periods, exactly 10 pulses.
- Pause: PRESET=10, counting; at COUNT=6 write EN=0 for 4 cycles → COUNT stays 6; re-enable → irq 6 cycles later.
- Byte writes: PRESET=0, write 0xAABBCCDD with byteen=0101 → PRESET=0x00BB00DD; COUNT write ignored; CTRL write 0xFFFFFFFF → CTRL reads 0xF.
- Collision: in the INT cycle of one-shot, write CTRL=0x9 → EN stays 1; COUNT reloads from PRESET next cycle.
